smash_router: RTL and testbench

- Parametrised five-port mesh router for the SMASH NoC, the successor to the single-lane time-slotted router.
- Each input port (up, right, down, left, local) has its own FIFO with configurable depth.
- Routing is deterministic XY: column first, then row.
- Each output port has an independent round-robin arbiter and a registered valid/ready output stage, so all five outputs can carry a flit in the same cycle.
- One instance per mesh node. The local port connects to the node's PCPI-side network interface.

---
 rtl/smash_router.sv | 195 +++++++++++++++++++
 tb/tb_smash_router.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/smash_router.sv
`default_nettype none
// ============================================================================
// Module      : smash_router
// Description : Five-port SMASH NoC mesh router. Each input (up, right, down,
//               left, local) has its own FIFO; heads are routed XY (column
//               first, then row); each output has an independent round-robin
//               arbiter feeding a registered valid/ready stage.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports (port index 0=up, 1=right, 2=down, 3=left, 4=local):
//   i_clk    in   1         clock, rising edge
//   i_rst    in   1         asynchronous active-high reset
//   i_valid  in   5         per-input flit valid
//   o_ready  out  5         per-input ready (FIFO not full)
//   i_flit   in   5*FLIT_W  input flits, slice p = [p*FLIT_W +: FLIT_W]
//   o_valid  out  5         per-output flit valid (registered)
//   i_ready  in   5         per-output downstream ready
//   o_flit   out  5*FLIT_W  output flits (registered), same slicing
// Flit layout: {dest_row, dest_col, payload}, FLIT_W = 2*ADDR_SIZE+DATA_SIZE.
// Optional feature macro: SMASH_ROUTER_BYPASS_EN
//   Defined   : an empty FIFO presents the incoming flit as its head in the
//               same cycle; if granted it skips the FIFO (1-cycle latency).
//   Undefined : every flit passes through its FIFO (2-cycle latency).
// ============================================================================
module smash_router #(
  parameter int ADDR_SIZE       = 4,
  parameter int DATA_SIZE       = 32,
  parameter int FIFO_DEPTH      = 2,
  parameter int ROUTER_ROW_ADDR = 0,
  parameter int ROUTER_COL_ADDR = 0
) (
  input  logic                                      i_clk,
  input  logic                                      i_rst,
  input  logic [4:0]                                i_valid,
  output logic [4:0]                                o_ready,
  input  logic [5*(2*ADDR_SIZE+DATA_SIZE)-1:0]      i_flit,
  output logic [4:0]                                o_valid,
  input  logic [4:0]                                i_ready,
  output logic [5*(2*ADDR_SIZE+DATA_SIZE)-1:0]      o_flit
);

  localparam int                   c_FLIT_W   = 2*ADDR_SIZE + DATA_SIZE;
  localparam int                   c_PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [c_PTR_W:0]     c_FULL_CNT = (c_PTR_W+1)'(FIFO_DEPTH);
  localparam logic [ADDR_SIZE-1:0] c_ROW      = ADDR_SIZE'(ROUTER_ROW_ADDR);
  localparam logic [ADDR_SIZE-1:0] c_COL      = ADDR_SIZE'(ROUTER_COL_ADDR);

  localparam logic [2:0] c_UP    = 3'd0;
  localparam logic [2:0] c_RIGHT = 3'd1;
  localparam logic [2:0] c_DOWN  = 3'd2;
  localparam logic [2:0] c_LEFT  = 3'd3;
  localparam logic [2:0] c_LOCAL = 3'd4;

  logic [4:0]          w_full;
  logic [4:0]          w_empty;
  logic [4:0]          w_head_vld;
  logic [4:0]          w_push;
  logic [4:0]          w_pop;
  logic [4:0]          w_pop_fifo;
  logic [c_FLIT_W-1:0] w_fifo_head [5];
  logic [c_FLIT_W-1:0] w_head      [5];
  logic [2:0]          w_route     [5];

  logic [4:0]          w_free;
  logic [4:0]          w_gnt_vld;
  logic [2:0]          w_gnt_idx   [5];
  logic [3:0]          w_cand;

  logic [4:0]          r_valid;
  logic [c_FLIT_W-1:0] r_flit      [5];
  logic [2:0]          r_ptr       [5];

  // --------------------------------------------------------------------------
  // Input FIFOs and XY route compute
  // --------------------------------------------------------------------------
  for (genvar p = 0; p < 5; p++) begin : g_port
    logic [c_FLIT_W-1:0]  r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]   r_wptr;
    logic [c_PTR_W-1:0]   r_rptr;
    logic [c_PTR_W:0]     r_count;
    logic [c_FLIT_W-1:0]  w_in;
    logic [ADDR_SIZE-1:0] w_row;
    logic [ADDR_SIZE-1:0] w_col;

    assign w_in           = i_flit[p*c_FLIT_W +: c_FLIT_W];
    assign w_full[p]      = (r_count == c_FULL_CNT);
    assign w_empty[p]     = (r_count == '0);
    assign w_fifo_head[p] = r_mem[r_rptr];

`ifdef SMASH_ROUTER_BYPASS_EN
    // An empty FIFO exposes the arriving flit directly; if it is granted this
    // cycle it never gets written, otherwise it is stored as usual.
    assign w_head[p]     = w_empty[p] ? w_in : w_fifo_head[p];
    assign w_head_vld[p] = ~w_empty[p] | i_valid[p];
    assign w_push[p]     = i_valid[p] & ~w_full[p] & ~(w_empty[p] & w_pop[p]);
`else
    assign w_head[p]     = w_fifo_head[p];
    assign w_head_vld[p] = ~w_empty[p];
    assign w_push[p]     = i_valid[p] & ~w_full[p];
`endif

    // A grant on an empty FIFO can only be a bypassed flit; storage untouched.
    assign w_pop_fifo[p] = w_pop[p] & ~w_empty[p];

    assign w_row = w_head[p][c_FLIT_W-1 -: ADDR_SIZE];
    assign w_col = w_head[p][DATA_SIZE +: ADDR_SIZE];

    // Column is resolved before row.
    assign w_route[p] = (w_col > c_COL) ? c_RIGHT :
                        (w_col < c_COL) ? c_LEFT  :
                        (w_row > c_ROW) ? c_DOWN  :
                        (w_row < c_ROW) ? c_UP    : c_LOCAL;

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
      end else begin
        if (w_push[p])     r_wptr <= r_wptr + 1'b1;
        if (w_pop_fifo[p]) r_rptr <= r_rptr + 1'b1;
        case ({w_push[p], w_pop_fifo[p]})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end

    // Storage needs no reset: occupancy is tracked by the pointers alone.
    always_ff @(posedge i_clk) begin
      if (w_push[p]) r_mem[r_wptr] <= w_in;
    end
  end

  // --------------------------------------------------------------------------
  // Per-output round-robin arbitration
  // --------------------------------------------------------------------------
  assign w_free = ~r_valid | i_ready;

  always_comb begin
    w_gnt_vld = '0;
    w_pop     = '0;
    w_cand    = '0;
    for (int o = 0; o < 5; o++) begin
      w_gnt_idx[o] = '0;
      // Walk candidates from farthest to nearest so that the requester closest
      // to (at or after) the pointer is the last one written and wins.
      for (int k = 4; k >= 0; k--) begin
        w_cand = {1'b0, r_ptr[o]} + 4'(k);
        if (w_cand >= 4'd5) w_cand = w_cand - 4'd5;
        if (w_head_vld[w_cand[2:0]] && (w_route[w_cand[2:0]] == 3'(o))) begin
          w_gnt_vld[o] = 1'b1;
          w_gnt_idx[o] = w_cand[2:0];
        end
      end
      // Each head has a single route, so at most one output pops a given FIFO.
      if (w_gnt_vld[o] && w_free[o]) w_pop[w_gnt_idx[o]] = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Registered output stages
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid <= '0;
      for (int o = 0; o < 5; o++) begin
        r_flit[o] <= '0;
        r_ptr[o]  <= '0;
      end
    end else begin
      for (int o = 0; o < 5; o++) begin
        if (w_free[o]) begin
          if (w_gnt_vld[o]) begin
            r_valid[o] <= 1'b1;
            r_flit[o]  <= w_head[w_gnt_idx[o]];
            r_ptr[o]   <= (w_gnt_idx[o] == c_LOCAL) ? c_UP : w_gnt_idx[o] + 3'd1;
          end else begin
            r_valid[o] <= 1'b0;
          end
        end
      end
    end
  end

  assign o_valid = r_valid;
  assign o_ready = ~w_full;

  for (genvar o = 0; o < 5; o++) begin : g_out
    assign o_flit[o*c_FLIT_W +: c_FLIT_W] = r_flit[o];
  end

endmodule
`default_nettype wire

// File: tb/tb_smash_router.sv
`default_nettype none
// ============================================================================
// Module      : tb_smash_router
// Description : Self-checking bench for smash_router at node (row 1, col 1).
//               Expected flits are queued per output when driven and popped
//               when the output handshakes; directed checks cover latency,
//               backpressure, round-robin order, parallel outputs and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_smash_router;

  localparam int FW = 40;

  logic            i_clk = 1'b0;
  logic            i_rst;
  logic [4:0]      i_valid;
  logic [4:0]      o_ready;
  logic [5*FW-1:0] i_flit;
  logic [4:0]      o_valid;
  logic [4:0]      i_ready;
  logic [5*FW-1:0] o_flit;

  int n_vec = 0;
  int n_err = 0;

  logic [FW-1:0] sb [5][$];

  always #5 i_clk = ~i_clk;

  smash_router #(
    .ADDR_SIZE      (4),
    .DATA_SIZE      (32),
    .FIFO_DEPTH     (2),
    .ROUTER_ROW_ADDR(1),
    .ROUTER_COL_ADDR(1)
  ) dut (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .i_flit (i_flit),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_flit (o_flit)
  );

  function automatic logic [FW-1:0] mk(input logic [3:0] r, input logic [3:0] c,
                                       input logic [31:0] d);
    return {r, c, d};
  endfunction

  function automatic logic [FW-1:0] out_flit(input int o);
    return o_flit[o*FW +: FW];
  endfunction

  task automatic check(input string tag, input logic [5*FW-1:0] obs,
                       input logic [5*FW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int p, input logic [FW-1:0] f);
    i_valid[p]          = 1'b1;
    i_flit[p*FW +: FW]  = f;
  endtask

  // Scoreboard pops at the falling edge (inputs are stable there and the
  // handshake completes on the following rising edge), then returns 2 time
  // units after the rising edge, which is where stimulus is applied.
  task automatic tick();
    logic [FW-1:0] e;
    @(negedge i_clk);
    if (!i_rst) begin
      for (int o = 0; o < 5; o++) begin
        if (o_valid[o] && i_ready[o]) begin
          n_vec++;
          assert (sb[o].size() > 0) else begin
            n_err++;
            $error("FAIL sb_extra_out%0d: observed flit %0h expected none", o, out_flit(o));
          end
          if (sb[o].size() > 0) begin
            e = sb[o].pop_front();
            check($sformatf("sb_out%0d", o), out_flit(o), e);
          end
        end
      end
    end
    @(posedge i_clk);
    #2;
  endtask

  initial begin
    logic [FW-1:0] f, fa, fb;
    logic [FW-1:0] f3 [3];
    int            t1_port [5] = '{1, 3, 2, 0, 4};
    logic [3:0]    t1_row  [5] = '{4'd1, 4'd1, 4'd2, 4'd0, 4'd1};
    logic [3:0]    t1_col  [5] = '{4'd2, 4'd0, 4'd1, 4'd1, 4'd1};
    int            src [3]     = '{0, 2, 3};
    int            seq [5];
    logic [4:0]    acc;
    int            cnt, first, last;

    i_rst   = 1'b1;
    i_valid = '0;
    i_ready = '1;
    i_flit  = '0;

    // Reset state
    repeat (2) tick();
    check("rst_o_valid", 200'(o_valid), '0);
    check("rst_o_flit", o_flit, '0);
    i_rst = 1'b0;
    tick();
    check("rst_o_ready", 200'(o_ready), 200'(5'h1F));

    // 1. Routing from local to every output, 2-cycle latency
    for (int k = 0; k < 5; k++) begin
      f = mk(t1_row[k], t1_col[k], 32'hA1 + 32'(k));
      drive(4, f);
      sb[t1_port[k]].push_back(f);
      tick();
      i_valid = '0;
      check($sformatf("t1_early%0d", k), 200'(o_valid), '0);
      tick();
      check($sformatf("t1_valid%0d", k), 200'(o_valid), 200'(5'b1 << t1_port[k]));
      check($sformatf("t1_flit%0d", k), 200'(out_flit(t1_port[k])), 200'(f));
    end

    // 2. Column resolved before row
    f = mk(4'd3, 4'd3, 32'hBEEF);
    drive(0, f);
    sb[1].push_back(f);
    tick();
    i_valid = '0;
    tick();
    check("t2_valid", 200'(o_valid), 200'(5'b00010));
    check("t2_flit", 200'(out_flit(1)), 200'(f));

    // 3. Backpressure on the right output
    tick();
    i_ready[1] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      f3[k] = mk(4'd1, 4'd2, 32'hC1 + 32'(k));
      sb[1].push_back(f3[k]);
      drive(4, f3[k]);
      tick();
    end
    i_valid = '0;
    check("t3_full", 200'(o_ready[4]), 200'(1'b0));
    check("t3_valid", 200'(o_valid[1]), 200'(1'b1));
    check("t3_head", 200'(out_flit(1)), 200'(f3[0]));
    repeat (2) tick();
    check("t3_hold", 200'(out_flit(1)), 200'(f3[0]));
    check("t3_still_full", 200'(o_ready[4]), 200'(1'b0));
    i_ready[1] = 1'b1;
    tick();
    check("t3_second_valid", 200'(o_valid[1]), 200'(1'b1));
    check("t3_second", 200'(out_flit(1)), 200'(f3[1]));
    tick();
    check("t3_third", 200'(out_flit(1)), 200'(f3[2]));
    tick();
    check("t3_drained", 200'(o_valid[1]), 200'(1'b0));
    check("t3_ready_back", 200'(o_ready[4]), 200'(1'b1));

    // 4. Round-robin onto local: up, down, left persistently requesting
    tick();
    for (int r = 0; r < 4; r++)
      for (int s = 0; s < 3; s++)
        sb[4].push_back(mk(4'd1, 4'd1, 32'hD000_0000 | (32'(src[s]) << 8) | 32'(r)));
    for (int p = 0; p < 5; p++) seq[p] = 0;
    cnt = 0; first = -1; last = -1;
    for (int c = 0; c < 30; c++) begin
      acc = '0;
      for (int s = 0; s < 3; s++) begin
        if (seq[src[s]] < 4) begin
          drive(src[s], mk(4'd1, 4'd1, 32'hD000_0000 | (32'(src[s]) << 8) | 32'(seq[src[s]])));
          acc[src[s]] = o_ready[src[s]];
        end else begin
          i_valid[src[s]] = 1'b0;
        end
      end
      tick();
      for (int p = 0; p < 5; p++) if (acc[p]) seq[p]++;
      if (o_valid[4]) begin
        cnt++;
        if (first < 0) first = c;
        last = c;
      end
    end
    i_valid = '0;
    check("t4_count", 200'(cnt), 200'(12));
    check("t4_back_to_back", 200'(last - first), 200'(11));

    // 5. Two outputs loaded in the same cycle
    tick();
    fa = mk(4'd2, 4'd1, 32'hE1);
    fb = mk(4'd0, 4'd1, 32'hE2);
    drive(0, fa);
    drive(2, fb);
    sb[2].push_back(fa);
    sb[0].push_back(fb);
    tick();
    i_valid = '0;
    tick();
    check("t5_valid", 200'(o_valid), 200'(5'b00101));
    check("t5_down", 200'(out_flit(2)), 200'(fa));
    check("t5_up", 200'(out_flit(0)), 200'(fb));

    // 6. Asynchronous reset mid-transfer
    tick();
    i_ready[1] = 1'b0;
    drive(4, mk(4'd1, 4'd2, 32'hF1));
    tick();
    drive(4, mk(4'd1, 4'd2, 32'hF2));
    tick();
    i_valid = '0;
    check("t6_pre_valid", 200'(o_valid[1]), 200'(1'b1));
    #1 i_rst = 1'b1;
    #1;
    check("t6_async_valid", 200'(o_valid), '0);
    check("t6_async_flit", o_flit, '0);
    check("t6_async_ready", 200'(o_ready), 200'(5'h1F));
    tick();
    i_rst   = 1'b0;
    i_ready = '1;
    tick();
    check("t6_flushed_a", 200'(o_valid), '0);
    tick();
    check("t6_flushed_b", 200'(o_valid), '0);
    fa = mk(4'd1, 4'd1, 32'h61);
    fb = mk(4'd1, 4'd1, 32'h64);
    drive(1, fa);
    drive(4, fb);
    sb[4].push_back(fa);
    sb[4].push_back(fb);
    tick();
    i_valid = '0;
    tick();
    check("t6_ptr_first_valid", 200'(o_valid[4]), 200'(1'b1));
    check("t6_ptr_first", 200'(out_flit(4)), 200'(fa));
    tick();
    check("t6_ptr_second", 200'(out_flit(4)), 200'(fb));

    // Everything queued must have come out
    repeat (4) tick();
    for (int o = 0; o < 5; o++)
      check($sformatf("sb_left_out%0d", o), 200'(sb[o].size()), '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
